// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM state encoding and the BCD digit type.
package bcd_pkg;

    localparam int unsigned BCD_MAX = 9;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StLap
    } state_e;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Command/status bundle between the stopwatch and its controller.
interface bcd_stopwatch_if #(
    parameter int unsigned DIGITS = 4
) ();

    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic                  down;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   display;
    logic                  running;
    logic                  wrap;
    logic                  overflow;
    logic                  load_err;

    modport master (
        output start, stop, clear, lap, down, load, load_value,
        input  count, display, running, wrap, overflow, load_err
    );

    modport slave (
        input  start, stop, clear, lap, down, load, load_value,
        output count, display, running, wrap, overflow, load_err
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: digit register with up/down step and ripple carry/borrow.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       down,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t digit_q, digit_d;
    logic       at_limit;

    always_comb begin
        at_limit = down ? (digit_q == 4'd0) : (digit_q == 4'(BCD_MAX));
        cout     = cin && at_limit;
        digit_d  = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (ld) begin
            digit_d = ld_val;
        end else if (cin) begin
            if (at_limit) begin
                digit_d = down ? 4'(BCD_MAX) : 4'd0;
            end else begin
                digit_d = down ? digit_q - 4'd1 : digit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-decade BCD stopwatch with prescaler, lap freeze, load and sticky overflow.
module bcd_stopwatch
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_stopwatch_if.slave  bus
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    snap_q, snap_d;
    logic [W-1:0]    count_w;
    logic [DIGITS:0] carry;
    logic            wrap_q, wrap_d;
    logic            ovf_q, ovf_d;
    logic            lerr_q, lerr_d;
    logic            active, tick, ld_valid, load_ok;
    logic            do_clear, do_stop, do_start, do_lap, do_load;

    // Only the highest-priority asserted command is acted upon.
    always_comb begin
        do_clear = bus.clear;
        do_stop  = !bus.clear && bus.stop;
        do_start = !bus.clear && !bus.stop && bus.start;
        do_lap   = !bus.clear && !bus.stop && !bus.start && bus.lap;
        do_load  = !bus.clear && !bus.stop && !bus.start && !bus.lap && bus.load;
    end

    always_comb begin
        ld_valid = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.load_value[4*i +: 4] > 4'(BCD_MAX)) begin
                ld_valid = 1'b0;
            end
        end
    end

    assign active  = (state_q == StRun) || (state_q == StLap);
    assign tick    = active && (presc_q == PW'(TICK_DIV - 1));
    assign load_ok = do_load && ld_valid && ((state_q == StIdle) || (state_q == StPause));
    assign carry[0] = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (do_clear),
            .ld     (load_ok),
            .ld_val (bus.load_value[4*g +: 4]),
            .down   (bus.down),
            .cin    (carry[g]),
            .digit  (count_w[4*g +: 4]),
            .cout   (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        unique case (state_q)
            StIdle, StPause: begin
                if (do_start) state_d = StRun;
            end
            StRun: begin
                if (do_stop) begin
                    state_d = StPause;
                end else if (do_lap) begin
                    state_d = StLap;
                    snap_d  = count_w;  // pre-tick value of this cycle
                end
            end
            StLap: begin
                if (do_stop) begin
                    state_d = StPause;
                end else if (do_lap) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        if (do_clear) begin
            state_d = StIdle;
            snap_d  = '0;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (do_clear || load_ok) begin
            presc_d = '0;
        end else if (active) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        wrap_d = carry[DIGITS] && !do_clear;
        ovf_d  = do_clear ? 1'b0 : (ovf_q || wrap_d);
        lerr_d = do_load && !load_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            snap_q  <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            snap_q  <= snap_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
        end
    end

    assign bus.count    = count_w;
    assign bus.display  = (state_q == StLap) ? snap_q : count_w;
    assign bus.running  = active;
    assign bus.wrap     = wrap_q;
    assign bus.overflow = ovf_q;
    assign bus.load_err = lerr_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: a TICK_DIV=1 and a TICK_DIV=3 instance sharing clk/rst_n.
module tb_bcd_stopwatch;

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] disp;
        logic        run;
        logic        wrp;
        logic        ovf;
        logic        lerr;
    } exp_t;

    typedef struct packed {
        logic [4:0]  cmd;   // {clear, stop, start, lap, load}
        logic [15:0] ldv;
        exp_t        exp;
    } step_t;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] CLR  = 5'b10000;
    localparam logic [4:0] STP  = 5'b01000;
    localparam logic [4:0] STA  = 5'b00100;
    localparam logic [4:0] LD   = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_stopwatch_if #(.DIGITS(4)) if1 ();
    bcd_stopwatch_if #(.DIGITS(4)) if3 ();

    bcd_stopwatch #(.DIGITS(4), .TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_stopwatch #(.DIGITS(4), .TICK_DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    function automatic exp_t mk(logic [15:0] c, logic [15:0] d, logic r, logic w, logic o,
                                logic l);
        return {c, d, r, w, o, l};
    endfunction

    function automatic step_t sp(logic [4:0] cmd, logic [15:0] ldv, exp_t e);
        return {cmd, ldv, e};
    endfunction

    function automatic logic [15:0] bcd(int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("cnt=%h disp=%h run=%b wrap=%b ovf=%b lerr=%b",
                         e.cnt, e.disp, e.run, e.wrp, e.ovf, e.lerr);
    endfunction

    function automatic exp_t obs1();
        return {if1.count, if1.display, if1.running, if1.wrap, if1.overflow, if1.load_err};
    endfunction

    function automatic exp_t obs3();
        return {if3.count, if3.display, if3.running, if3.wrap, if3.overflow, if3.load_err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        {if1.clear, if1.stop, if1.start, if1.lap, if1.load} = '0;
        {if3.clear, if3.stop, if3.start, if3.lap, if3.load} = '0;
    endtask

    task automatic drive1(step_t s);
        {if1.clear, if1.stop, if1.start, if1.lap, if1.load} = s.cmd;
        if1.load_value = s.ldv;
    endtask

    task automatic test_reset();
        exp_t e, o;
        {if1.clear, if1.stop, if1.start, if1.lap, if1.load, if1.down} = '0;
        {if3.clear, if3.stop, if3.start, if3.lap, if3.load, if3.down} = '0;
        if1.load_value = '0;
        if3.load_value = '0;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(16'h0, 16'h0, 0, 0, 0, 0));
            sb.push_back(mk(16'h0, 16'h0, 0, 0, 0, 0));
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL reset1[%0d]: got %s want %s", k, fmt(o), fmt(e));
            end
            e = sb.pop_front(); o = obs3(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL reset3[%0d]: got %s want %s", k, fmt(o), fmt(e));
            end
            if (k == 1) rst_n = 1'b1;
            cyc();
        end
    endtask

    task automatic test_count();
        step_t st[$];
        exp_t  e, o;
        st.push_back(sp(STA, 16'h0, mk(16'h0, 16'h0, 1, 0, 0, 0)));
        for (int i = 1; i <= 11; i++) st.push_back(sp(NONE, 16'h0, mk(bcd(i), bcd(i), 1, 0, 0, 0)));
        st.push_back(sp(STP, 16'h0, mk(16'h0012, 16'h0012, 0, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0, mk(16'h0012, 16'h0012, 0, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0, mk(16'h0012, 16'h0012, 0, 0, 0, 0)));
        st.push_back(sp(CLR, 16'h0, mk(16'h0, 16'h0, 0, 0, 0, 0)));
        foreach (st[i]) begin
            drive1(st[i]);
            sb.push_back(st[i].exp);
            cyc();
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL count[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_wrap_up();
        step_t st[$];
        exp_t  e, o;
        if1.down = 1'b0;
        st.push_back(sp(LD,   16'h9998, mk(16'h9998, 16'h9998, 0, 0, 0, 0)));
        st.push_back(sp(STA,  16'h0,    mk(16'h9998, 16'h9998, 1, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h9999, 16'h9999, 1, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h0000, 16'h0000, 1, 1, 1, 0)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h0001, 16'h0001, 1, 0, 1, 0)));
        st.push_back(sp(STP,  16'h0,    mk(16'h0002, 16'h0002, 0, 0, 1, 0)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h0002, 16'h0002, 0, 0, 1, 0)));
        st.push_back(sp(CLR,  16'h0,    mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        foreach (st[i]) begin
            drive1(st[i]);
            sb.push_back(st[i].exp);
            cyc();
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL wrap_up[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_wrap_down();
        step_t st[$];
        exp_t  e, o;
        if1.down = 1'b1;
        st.push_back(sp(LD,   16'h0001, mk(16'h0001, 16'h0001, 0, 0, 0, 0)));
        st.push_back(sp(STA,  16'h0,    mk(16'h0001, 16'h0001, 1, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h0000, 16'h0000, 1, 0, 0, 0)));
        st.push_back(sp(STP,  16'h0,    mk(16'h9999, 16'h9999, 0, 1, 1, 0)));
        st.push_back(sp(LD,   16'h12A4, mk(16'h9999, 16'h9999, 0, 0, 1, 1)));
        st.push_back(sp(NONE, 16'h0,    mk(16'h9999, 16'h9999, 0, 0, 1, 0)));
        st.push_back(sp(LD,   16'h4321, mk(16'h4321, 16'h4321, 0, 0, 1, 0)));
        st.push_back(sp(STA,  16'h0,    mk(16'h4321, 16'h4321, 1, 0, 1, 0)));
        st.push_back(sp(LD,   16'h1111, mk(16'h4320, 16'h4320, 1, 0, 1, 1)));
        st.push_back(sp(CLR,  16'h0,    mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        foreach (st[i]) begin
            drive1(st[i]);
            sb.push_back(st[i].exp);
            cyc();
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL wrap_down[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        if1.down = 1'b0;
    endtask

    task automatic test_lap();
        int   cnt = 0, pre = 0, laps = 0, snap = 0;
        bit   in_lap = 0, tick;
        exp_t e, o;
        if3.start = 1'b1;
        sb.push_back(mk(16'h0, 16'h0, 1, 0, 0, 0));
        cyc();
        e = sb.pop_front(); o = obs3(); n_cmp++;
        if (o !== e) begin
            n_err++; $display("FAIL lap_start: got %s want %s", fmt(o), fmt(e));
        end
        for (int s = 0; s < 40; s++) begin
            // First lap lands on a tick cycle, so the snapshot must be the pre-tick value.
            if (laps == 0 && cnt == 5 && pre == 2) begin
                if3.lap = 1'b1; laps = 1; in_lap = 1; snap = cnt;
            end else if (laps == 1 && s == 30) begin
                if3.lap = 1'b1; laps = 2; in_lap = 0;
            end
            tick = (pre == 2);
            pre  = tick ? 0 : pre + 1;
            if (tick) cnt++;
            sb.push_back(mk(bcd(cnt), in_lap ? bcd(snap) : bcd(cnt), 1, 0, 0, 0));
            cyc();
            e = sb.pop_front(); o = obs3(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL lap[%0d]: got %s want %s", s, fmt(o), fmt(e));
            end
        end
        if (laps != 2) begin
            n_err++; $display("FAIL lap_reached: got %0d laps want 2", laps);
        end
        if3.clear = 1'b1;
        sb.push_back(mk(16'h0, 16'h0, 0, 0, 0, 0));
        cyc();
        e = sb.pop_front(); o = obs3(); n_cmp++;
        if (o !== e) begin
            n_err++; $display("FAIL lap_clear: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_clear_tick();
        step_t st[$];
        exp_t  e, o;
        st.push_back(sp(STA,       16'h0,    mk(16'h0000, 16'h0000, 1, 0, 0, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0001, 16'h0001, 1, 0, 0, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0002, 16'h0002, 1, 0, 0, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0003, 16'h0003, 1, 0, 0, 0)));
        st.push_back(sp(CLR,       16'h0,    mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        st.push_back(sp(CLR | STA, 16'h0,    mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        st.push_back(sp(LD,        16'h9999, mk(16'h9999, 16'h9999, 0, 0, 0, 0)));
        st.push_back(sp(STA,       16'h0,    mk(16'h9999, 16'h9999, 1, 0, 0, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0000, 16'h0000, 1, 1, 1, 0)));
        st.push_back(sp(NONE,      16'h0,    mk(16'h0001, 16'h0001, 1, 0, 1, 0)));
        foreach (st[i]) begin
            drive1(st[i]);
            sb.push_back(st[i].exp);
            cyc();
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL clear_tick[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
        // Reset mid-cycle while running with overflow set: outputs must drop without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back(mk(16'h0, 16'h0, 0, 0, 0, 0));
        e = sb.pop_front(); o = obs1(); n_cmp++;
        if (o !== e) begin
            n_err++; $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e));
        end
        cyc();
        rst_n = 1'b1;
        st.delete();
        st.push_back(sp(NONE, 16'h0, mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0, mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        st.push_back(sp(STA,  16'h0, mk(16'h0000, 16'h0000, 1, 0, 0, 0)));
        st.push_back(sp(NONE, 16'h0, mk(16'h0001, 16'h0001, 1, 0, 0, 0)));
        st.push_back(sp(CLR,  16'h0, mk(16'h0000, 16'h0000, 0, 0, 0, 0)));
        foreach (st[i]) begin
            drive1(st[i]);
            sb.push_back(st[i].exp);
            cyc();
            e = sb.pop_front(); o = obs1(); n_cmp++;
            if (o !== e) begin
                n_err++; $display("FAIL post_reset[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count();
        test_wrap_up();
        test_wrap_down();
        test_lap();
        test_clear_tick();
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
